// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Optional macro MDU_EARLY_OUT_EN: multiplies stop once the remaining multiplier is zero.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_in,
   input  logic [1:0]       op_in,
   input  logic [WIDTH-1:0] opA_in,
   input  logic [WIDTH-1:0] opB_in,
   input  logic             mthi_in,
   input  logic             mtlo_in,
   input  logic [WIDTH-1:0] mt_data_in,
   output logic             busy_out,
   output logic             done_out,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t             state, state_next;
   logic [5:0]         cnt;
   logic               is_div, neg_q, neg_r, b_zero;
   logic [WIDTH-1:0]   a_raw, b_mag;
   logic [2*WIDTH-1:0] acc, mcand;

   logic [WIDTH-1:0]   a_mag_in, b_mag_in;
   logic               last_iter;
   logic [WIDTH:0]     trial, diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   q_fix, r_fix;

   assign a_mag_in = (op_in[0] && opA_in[WIDTH-1]) ? -opA_in : opA_in;
   assign b_mag_in = (op_in[0] && opB_in[WIDTH-1]) ? -opB_in : opB_in;

   // Divide keeps {remainder, quotient} in acc; the trial pulls in the next dividend bit.
   assign trial = acc[2*WIDTH-1:WIDTH-1];
   assign diff  = trial - {1'b0, b_mag};

   assign prod_fix = neg_q ? -acc : acc;
   assign q_fix    = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign r_fix    = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

`ifdef MDU_EARLY_OUT_EN
   assign last_iter = (cnt == 6'(WIDTH-1)) || (!is_div && b_mag[WIDTH-1:1] == '0);
`else
   assign last_iter = (cnt == 6'(WIDTH-1));
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // NOTE: next_state gets its default first so no path through this block infers a latch.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (start_in) state_next = RUN;
         RUN:     if (last_iter) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: operand/working registers are deliberately not reset; they are always loaded before use.
         hi_out   <= '0;
         lo_out   <= '0;
         busy_out <= 1'b0;
         done_out <= 1'b0;
         cnt      <= '0;
      end else begin
         busy_out <= (state_next != IDLE);
         done_out <= (state == FIX);
         unique case (state)
            IDLE: begin
               if (start_in) begin
                  cnt    <= '0;
                  is_div <= op_in[1];
                  neg_q  <= op_in[0] & (opA_in[WIDTH-1] ^ opB_in[WIDTH-1]);
                  neg_r  <= op_in[0] & opA_in[WIDTH-1];
                  b_zero <= (opB_in == '0);
                  a_raw  <= opA_in;
                  b_mag  <= b_mag_in;
                  mcand  <= {{WIDTH{1'b0}}, a_mag_in};
                  acc    <= op_in[1] ? {{WIDTH{1'b0}}, a_mag_in} : '0;
               end else begin
                  if (mthi_in) hi_out <= mt_data_in;
                  if (mtlo_in) lo_out <= mt_data_in;
               end
            end
            RUN: begin
               cnt <= cnt + 6'd1;
               if (is_div) begin
                  if (!diff[WIDTH]) acc <= {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                  else              acc <= {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               end else begin
                  if (b_mag[0]) acc <= acc + mcand;
                  mcand <= mcand << 1;
                  b_mag <= b_mag >> 1;
               end
            end
            FIX: begin
               if (!is_div) begin
                  hi_out <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_out <= prod_fix[WIDTH-1:0];
               end else if (b_zero) begin
                  hi_out <= a_raw;
                  lo_out <= '1;
               end else begin
                  hi_out <= r_fix;
                  lo_out <= q_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a driver pushes reference results, a monitor checks each done_out.
// Honours MDU_EARLY_OUT_EN for the expected multiply latency.
module tb_mult_div_unit;

   logic        clk = 1'b0, reset = 1'b1, start_in = 1'b0;
   logic [1:0]  op_in = '0;
   logic [31:0] opA_in = '0, opB_in = '0, mt_data_in = '0;
   logic        mthi_in = 1'b0, mtlo_in = 1'b0;
   logic        busy_out, done_out;
   logic [31:0] hi_out, lo_out;

   mult_div_unit #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start_in(start_in), .op_in(op_in),
      .opA_in(opA_in), .opB_in(opB_in), .mthi_in(mthi_in), .mtlo_in(mtlo_in),
      .mt_data_in(mt_data_in), .busy_out(busy_out), .done_out(done_out),
      .hi_out(hi_out), .lo_out(lo_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t        sb[$];
   int          errors = 0, checks = 0, cyc = 0;
   logic [31:0] hi_m = '0, lo_m = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic int bitlen(input logic [31:0] v);
      int n = 0;
      for (int i = 0; i < 32; i++) if (v[i]) n = i + 1;
      return n;
   endfunction

   // Reference results straight from the architectural definitions of each instruction.
   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      sa, sb2;
      logic [63:0] p;
      logic [31:0] mag;
      int          sai, sbi;
      e.lat = 34;
      e.acc_cyc = 0;
      mag = b;
      case (op)
         2'b00: begin
            p = {32'b0, a} * {32'b0, b};
            e.hi = p[63:32]; e.lo = p[31:0];
         end
         2'b01: begin
            sa = longint'($signed(a)); sb2 = longint'($signed(b));
            p = 64'(sa * sb2);
            e.hi = p[63:32]; e.lo = p[31:0];
            mag = b[31] ? (~b + 32'd1) : b;
         end
         2'b10: begin
            if (b == 0) begin e.hi = a; e.lo = 32'hFFFF_FFFF; end
            else begin e.lo = a / b; e.hi = a % b; end
         end
         default: begin
            if (b == 0) begin
               e.hi = a; e.lo = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.lo = 32'h8000_0000; e.hi = 0;
            end else begin
               sai = $signed(a); sbi = $signed(b);
               e.lo = 32'(sai / sbi); e.hi = 32'(sai % sbi);
            end
         end
      endcase
`ifdef MDU_EARLY_OUT_EN
      if (!op[1]) e.lat = 2 + ((bitlen(mag) > 1) ? bitlen(mag) : 1);
`endif
      return e;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!reset && done_out) begin
         if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            check("result_hi", hi_out, e.hi);
            check("result_lo", lo_out, e.lo);
            check("latency", cyc - e.acc_cyc + 1, e.lat);
            check("busy_at_done", busy_out, 0);
            hi_m = e.hi;
            lo_m = e.lo;
         end
      end
   end

   task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      @(negedge clk);
      start_in = 1'b1; op_in = op; opA_in = a; opB_in = b;
      @(posedge clk);
      #1;
      e = model(op, a, b);
      e.acc_cyc = cyc;
      sb.push_back(e);
      start_in = 1'b0; opA_in = $urandom; opB_in = $urandom;
      check("busy_after_accept", busy_out, 1);
   endtask

   task automatic wait_drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         check("done_timeout", 0, 1);
         sb.delete();
      end
      @(negedge clk);
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      issue(op, a, b);
      wait_drain();
   endtask

   task automatic mt_write(input logic [31:0] d, input logic applied);
      @(negedge clk);
      mthi_in = 1'b1; mtlo_in = 1'b1; mt_data_in = d;
      @(posedge clk);
      #1;
      mthi_in = 1'b0; mtlo_in = 1'b0; mt_data_in = $urandom;
      if (applied) begin hi_m = d; lo_m = d; end
      @(negedge clk);
      check("mt_hi", hi_out, hi_m);
      check("mt_lo", lo_out, lo_m);
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] corner[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
      if ($urandom_range(3) == 0) return corner[$urandom_range(4)];
      if ($urandom_range(3) == 0) return 32'($urandom_range(200));
      return $urandom;
   endfunction

   initial begin
      repeat (3) @(negedge clk);
      reset = 1'b0;
      check("reset_busy", busy_out, 0);
      check("reset_done", done_out, 0);
      check("reset_hi", hi_out, 0);
      check("reset_lo", lo_out, 0);

      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007);
      run_op(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
      run_op(2'b10, 32'd100, 32'd7);
      run_op(2'b10, 32'd5, 32'd0);
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op(2'b00, 32'h1234_5678, 32'd0);

      mt_write(32'h0000_1234, 1'b1);

      issue(2'b10, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      mt_write(32'hDEAD_BEEF, 1'b0);
      wait_drain();
      check("post_busy_mt_hi", hi_out, 32'd2);

      // A second start while busy must vanish; the monitor flags any extra done.
      issue(2'b10, 32'd1000, 32'd3);
      repeat (4) @(negedge clk);
      start_in = 1'b1; op_in = 2'b00; opA_in = 32'd9; opB_in = 32'd9;
      @(posedge clk);
      #1;
      start_in = 1'b0;
      wait_drain();
      repeat (40) @(negedge clk);

      issue(2'b10, 32'hFFFF_0000, 32'd13);
      repeat (10) @(negedge clk);
      reset = 1'b1;
      sb.delete();
      @(negedge clk);
      reset = 1'b0;
      hi_m = '0; lo_m = '0;
      check("abort_busy", busy_out, 0);
      check("abort_hi", hi_out, 0);
      check("abort_lo", lo_out, 0);
      check("abort_done", done_out, 0);
      repeat (40) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         run_op(2'($urandom_range(3)), pick_operand(), pick_operand());
         if (i % 10 == 5) mt_write($urandom, 1'b1);
      end

      repeat (5) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
